sec_fault_queue: RTL

Buffers SMEP/SMAP permission faults from the load/store/fetch permission-check stage and presents them one at a time to the exception/commit logic over a valid/ready handshake. Sits directly downstream of the SMEP/SMAP checker. Each checked access that faults is captured with its virtual address, access kind and ROB tag into a small FIFO. Faults that arrive while the FIFO is full are dropped and counted.

---
 rtl/sec_fault_queue_if.sv | 32 +++
 rtl/sec_fault_queue.sv | 88 ++++++++
 2 files changed

// File: rtl/sec_fault_queue_if.sv
// Handshake bundle between the SMEP/SMAP checker, the fault queue and the
// exception/commit logic. Signal suffixes are from the queue's point of view.
interface sec_fault_queue_if #(
    parameter int VA_W  = 64,
    parameter int ROB_W = 6
);
    logic             chk_valid_i;
    logic             chk_fault_i;
    logic             chk_exec_i;
    logic [VA_W-1:0]  chk_va_i;
    logic [ROB_W-1:0] chk_rob_i;

    logic             exc_valid_o;
    logic             exc_ready_i;
    logic             exc_exec_o;
    logic [VA_W-1:0]  exc_va_o;
    logic [ROB_W-1:0] exc_rob_o;

    // Queue side: consumes checker results, produces the head entry.
    modport slave (
        input  chk_valid_i, chk_fault_i, chk_exec_i, chk_va_i, chk_rob_i,
        input  exc_ready_i,
        output exc_valid_o, exc_exec_o, exc_va_o, exc_rob_o
    );

    // Environment side: drives checker results and the consumer ready.
    modport master (
        output chk_valid_i, chk_fault_i, chk_exec_i, chk_va_i, chk_rob_i,
        output exc_ready_i,
        input  exc_valid_o, exc_exec_o, exc_va_o, exc_rob_o
    );
endinterface

// File: rtl/sec_fault_queue.sv
// SMEP/SMAP permission-fault queue: captures faulting checks into a small
// circular FIFO and presents them in arrival order over valid/ready.
// Faults arriving while full (and not popping) are dropped and counted.
module sec_fault_queue #(
    parameter int VA_W  = 64,
    parameter int ROB_W = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    sec_fault_queue_if.slave           bus,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_W-1:0]           ovf_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic             mem_exec_q [DEPTH];
    logic [VA_W-1:0]  mem_va_q   [DEPTH];
    logic [ROB_W-1:0] mem_rob_q  [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [CNT_W-1:0] ovf_q,    ovf_d;

    logic fault_in, full, push, pop, drop;

    assign fault_in = bus.chk_valid_i & bus.chk_fault_i & ~flush_i;
    assign full     = (count_q == FULL_CNT);
    assign pop      = (count_q != '0) & bus.exc_ready_i & ~flush_i;
    // A full queue still accepts a fault when the head leaves the same cycle.
    assign push     = fault_in & (~full | pop);
    assign drop     = fault_in & full & ~pop;

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (drop && (ovf_q != '1)) ovf_d = ovf_q + CNT_W'(1);
        end
    end

    // Control state; the overflow count survives flush, only reset clears it.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage is written only on push and never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_exec_q[wr_ptr_q] <= bus.chk_exec_i;
            mem_va_q[wr_ptr_q]   <= bus.chk_va_i;
            mem_rob_q[wr_ptr_q]  <= bus.chk_rob_i;
        end
    end

    assign bus.exc_valid_o = (count_q != '0);
    assign bus.exc_exec_o  = mem_exec_q[rd_ptr_q];
    assign bus.exc_va_o    = mem_va_q[rd_ptr_q];
    assign bus.exc_rob_o   = mem_rob_q[rd_ptr_q];
    assign count_o         = count_q;
    assign ovf_cnt_o       = ovf_q;
endmodule
